ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a controller and the PS/2 host transmitter.
// The controller side is the master; the transmitter side is the slave.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts a command byte out on device-generated clocks and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave bus
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic clk_fall;
  logic timed_out;

  // Pad synchronizers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall  = clk_prev_q & ~clk_sync_q;
  assign timed_out = (tout_q == TIMEOUT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      tout_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tout_q    <= tout_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tout_d    = tout_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        phase_d   = '0;
        tout_d    = '0;
        bit_idx_d = '0;
        if (bus.tx_valid) begin
          shreg_d  = bus.tx_data;
          parity_d = ~^bus.tx_data;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (phase_q == INHIBIT_LAST) begin
          phase_d   = '0;
          data_oe_d = 1'b1;
          state_d   = REQUEST;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      REQUEST: begin
        if (phase_q == SETUP_LAST) begin
          phase_d   = '0;
          tout_d    = '0;
          bit_idx_d = '0;
          state_d   = SHIFT;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      SHIFT: begin
        if (timed_out) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          tout_d    = '0;
          state_d   = IDLE;
        end else begin
          tout_d = tout_q + TW'(1);
          if (clk_fall) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              data_oe_d = ~shreg_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end
          end
        end
      end

      ACK: begin
        if (timed_out) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          tout_d    = '0;
          state_d   = IDLE;
        end else begin
          tout_d = tout_q + TW'(1);
          if (clk_fall) begin
            if (!data_sync_q) begin
              state_d = WAIT_IDLE;
            end else begin
              error_d = 1'b1;
              tout_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end

      WAIT_IDLE: begin
        // Timeout wins over a completion seen in the same cycle.
        if (timed_out) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          tout_d    = '0;
          state_d   = IDLE;
        end else if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          tout_d  = '0;
          state_d = IDLE;
        end else begin
          tout_d = tout_q + TW'(1);
        end
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe   = (state_q == INHIBIT) || (state_q == REQUEST);
  assign ps2_data_oe  = data_oe_q;
  assign bus.tx_ready = (state_q == IDLE);
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain PS/2 device model clocks
// frames, ACKs or NACKs, and the bench checks line bits, phases and pulses.
module tb_ps2_host_tx;

  localparam int INHIBIT = 40;
  localparam int SETUP   = 8;
  localparam int TIMEOUT = 3000;

  logic clock;
  logic resetn;
  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic clk_line;
  logic data_line;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .bus         (bus)
  );

  // Wired-AND bus with pull-ups: either side pulling low wins.
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int done_total = 0;
  int error_total = 0;
  int both_total = 0;
  int inhibit_total = 0;
  int setup_total = 0;

  always @(negedge clock) begin
    if (bus.tx_done) done_total++;
    if (bus.tx_error) error_total++;
    if (bus.tx_done && bus.tx_error) both_total++;
    if (ps2_clk_oe && !ps2_data_oe) inhibit_total++;
    if (ps2_clk_oe && ps2_data_oe) setup_total++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit keep_valid);
    @(negedge clock);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    if (!keep_valid) begin
      @(negedge clock);
      bus.tx_valid = 1'b0;
      bus.tx_data  = ~d;
    end
  endtask

  // Device model: waits for the host to release clock with start bit low,
  // then produces n_edges falling edges, recording the line before each one.
  task automatic run_device(input int n_edges, input bit do_ack, input int hold,
                            output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    @(negedge clock);
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < INHIBIT + SETUP + 100) begin
      @(negedge clock);
      w++;
    end
    if (w >= INHIBIT + SETUP + 100) begin
      checkOutput("dev_start_seen", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < n_edges; i++) begin
      repeat (8) @(negedge clock);
      bits[i] = data_line;
      if (i == 10 && do_ack) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (8 + ((i == 10) ? hold : 0)) @(negedge clock);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int w;
    w = 0;
    while (!bus.tx_ready && w < limit) begin
      @(negedge clock);
      w++;
    end
    if (w >= limit) checkOutput(tag, 32'd0, 32'd1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [10:0] bits;
    int s_done, s_err, s_inh, s_set, n, viol;

    resetn       = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    repeat (3) @(negedge clock);
    checkOutput("rst_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.tx_busy), 32'd0);
    checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // 0xED, ACKed frame
    s_done = done_total; s_err = error_total; s_inh = inhibit_total; s_set = setup_total;
    applyStimulus(8'hED, 1'b0);
    checkOutput("ed_busy", 32'(bus.tx_busy), 32'd1);
    run_device(11, 1'b1, 0, bits);
    wait_ready("ed_ready_wait", 100);
    checkOutput("ed_bits", 32'(bits), 32'h7DA);
    checkOutput("ed_inhibit_len", 32'(inhibit_total - s_inh), 32'(INHIBIT));
    checkOutput("ed_setup_len", 32'(setup_total - s_set), 32'(SETUP));
    checkOutput("ed_done", 32'(done_total - s_done), 32'd1);
    checkOutput("ed_error", 32'(error_total - s_err), 32'd0);

    // 0xFF, device NACKs
    s_done = done_total; s_err = error_total;
    applyStimulus(8'hFF, 1'b0);
    run_device(11, 1'b0, 0, bits);
    wait_ready("ff_ready_wait", 100);
    checkOutput("ff_bits", 32'(bits), 32'h7FE);
    checkOutput("ff_parity", 32'(bits[9]), 32'd1);
    checkOutput("ff_error", 32'(error_total - s_err), 32'd1);
    checkOutput("ff_done", 32'(done_total - s_done), 32'd0);
    checkOutput("ff_ready", 32'(bus.tx_ready), 32'd1);

    // 0x01, device never clocks -> timeout
    s_done = done_total; s_err = error_total;
    applyStimulus(8'h01, 1'b0);
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INHIBIT + SETUP + 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("to_shift_seen", 32'(n < INHIBIT + SETUP + 100), 32'd1);
    n = 0;
    viol = 0;
    while (!bus.tx_error && n < TIMEOUT + 20) begin
      if (ps2_data_oe !== 1'b1) viol++;
      @(negedge clock);
      n++;
    end
    checkOutput("to_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("to_start_held", 32'(viol), 32'd0);
    checkOutput("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("to_data_oe", 32'(ps2_data_oe), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("to_error", 32'(error_total - s_err), 32'd1);
    checkOutput("to_done", 32'(done_total - s_done), 32'd0);

    // 0x00, reset after the fourth data bit
    s_done = done_total; s_err = error_total;
    applyStimulus(8'h00, 1'b0);
    run_device(5, 1'b0, 0, bits);
    checkOutput("rm_bits", 32'(bits[4:0]), 32'd0);
    checkOutput("rm_data_oe_pre", 32'(ps2_data_oe), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rm_data_oe_async", 32'(ps2_data_oe), 32'd0);
    checkOutput("rm_ready_async", 32'(bus.tx_ready), 32'd1);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("rm_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("rm_pulses", 32'((done_total - s_done) + (error_total - s_err)), 32'd0);

    // reset during inhibit drops the clock pull immediately
    applyStimulus(8'h55, 1'b0);
    repeat (10) @(negedge clock);
    checkOutput("ri_clk_oe_pre", 32'(ps2_clk_oe), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("ri_clk_oe_async", 32'(ps2_clk_oe), 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // tx_valid held: 0xF4 then 0xED back-to-back
    s_done = done_total; s_err = error_total;
    applyStimulus(8'hF4, 1'b1);
    @(negedge clock);
    bus.tx_data = 8'hED;
    run_device(11, 1'b1, 0, bits);
    checkOutput("bb_bits1", 32'(bits), 32'h5E8);
    n = 0;
    while ((done_total - s_done) < 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!bus.tx_busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bb_second_accept", 32'(bus.tx_busy), 32'd1);
    bus.tx_valid = 1'b0;
    run_device(11, 1'b1, 0, bits);
    wait_ready("bb_ready_wait", 100);
    checkOutput("bb_bits2", 32'(bits), 32'h7DA);
    checkOutput("bb_done", 32'(done_total - s_done), 32'd2);
    checkOutput("bb_error", 32'(error_total - s_err), 32'd0);

    // ACK with clock held low 20 extra cycles
    s_done = done_total; s_err = error_total;
    applyStimulus(8'h55, 1'b0);
    run_device(11, 1'b1, 20, bits);
    checkOutput("hold_no_early_done", 32'(done_total - s_done), 32'd0);
    wait_ready("hold_ready_wait", 100);
    repeat (20) @(negedge clock);
    checkOutput("hold_bits", 32'(bits), 32'h6AA);
    checkOutput("hold_done", 32'(done_total - s_done), 32'd1);
    checkOutput("hold_error", 32'(error_total - s_err), 32'd0);

    checkOutput("done_error_overlap", 32'(both_total), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
